// File: rtl/lsu_stage_pkg.sv
// ----------------------------------------------------------------------------
// lsu_stage_pkg
// Shared definitions for the load/store pipeline stage:
//   - FSM state encoding (IDLE=0, REQ=1, RESP=2)
//   - bit indices of the one-hot load/store type vectors from execute
//   - exception cause codes raised for misaligned accesses
// No ports (package).
// ----------------------------------------------------------------------------
package lsu_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // One-hot load type bits (EX_LS_reg_load_sign)
  localparam int LD_LB  = 0;
  localparam int LD_LH  = 1;
  localparam int LD_LW  = 2;
  localparam int LD_LBU = 3;
  localparam int LD_LHU = 4;

  // One-hot store type bits (EX_LS_reg_store_sign); bit 3 is reserved
  localparam int SD_SB = 0;
  localparam int SD_SH = 1;
  localparam int SD_SW = 2;

  // Cause codes for misaligned accesses
  localparam logic [31:0] CAUSE_LOAD_MISALIGN  = 32'd4;
  localparam logic [31:0] CAUSE_STORE_MISALIGN = 32'd6;

endpackage

// File: rtl/lsu_stage_load_align.sv
// ----------------------------------------------------------------------------
// lsu_load_align
// Combinational extraction of the addressed byte/half/word from a returned
// memory word, followed by sign or zero extension according to load type.
// Ports:
//   rdata     in  DATA_LEN  word returned by data memory
//   addr_lo   in  2         low byte-address bits of the load
//   load_sign in  5         one-hot load type [0]lb [1]lh [2]lw [3]lbu [4]lhu
//   load_data out DATA_LEN  extended value for writeback
// Half-word selection uses addr_lo[1] only; word loads ignore addr_lo.
// ----------------------------------------------------------------------------
module lsu_load_align
  import lsu_stage_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [DATA_LEN-1:0] rdata,
  input  logic [1:0]          addr_lo,
  input  logic [4:0]          load_sign,
  output logic [DATA_LEN-1:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and half-word lanes
  always_comb begin
    byte_s = rdata[7:0];
    half_s = rdata[15:0];
    case (addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extend the selected lane according to the load type
  always_comb begin
    load_data = rdata;
    if (load_sign[LD_LB]) begin
      load_data = {{(DATA_LEN-8){byte_s[7]}}, byte_s};
    end else if (load_sign[LD_LH]) begin
      load_data = {{(DATA_LEN-16){half_s[15]}}, half_s};
    end else if (load_sign[LD_LBU]) begin
      load_data = {{(DATA_LEN-8){1'b0}}, byte_s};
    end else if (load_sign[LD_LHU]) begin
      load_data = {{(DATA_LEN-16){1'b0}}, half_s};
    end else begin
      load_data = rdata;
    end
  end

endmodule

// File: rtl/lsu_stage.sv
// ----------------------------------------------------------------------------
// lsu_stage
// Memory-access pipeline stage between execute and writeback. Non-memory
// instructions pass through in one cycle; loads and stores are captured into
// holding registers and issued on a req/gnt/rvalid data-memory port while
// LS_reg_ready is held low to stall execute.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   EX_LS_reg_*              instruction bundle from execute
//   LS_reg_ready             1 when the stage can accept (FSM in IDLE)
//   mem_req/mem_gnt          request handshake
//   mem_we/addr/wdata/wstrb  request payload (word-aligned address,
//                            lane-replicated data, byte strobes)
//   mem_rvalid/mem_rdata     load response
//   LS_WB_reg_*              registered result bundle to writeback
//
// Build option: LSU_MISALIGN_EXC_EN
//   defined   - misaligned lh/lhu/sh/lw/sw raise an exception in one cycle
//               (cause 4 load / 6 store) without touching memory
//   undefined - low address bits are ignored for alignment and the access
//               proceeds normally
// ----------------------------------------------------------------------------
module lsu_stage
  import lsu_stage_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                EX_LS_reg_execute_valid,
  input  logic [DATA_LEN-1:0] EX_LS_reg_dest_data,
  input  logic [DATA_LEN-1:0] EX_LS_reg_addr_load,
  input  logic [DATA_LEN-1:0] EX_LS_reg_store_data,
  input  logic [4:0]          EX_LS_reg_load_sign,
  input  logic [3:0]          EX_LS_reg_store_sign,
  input  logic [4:0]          EX_LS_reg_rd,
  input  logic                EX_LS_reg_dest_wen,
  input  logic                EX_LS_reg_unusual_flag,
  input  logic [DATA_LEN-1:0] EX_LS_reg_cause,
  output logic                LS_reg_ready,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_we,
  output logic [DATA_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic [3:0]          mem_wstrb,
  input  logic                mem_rvalid,
  input  logic [DATA_LEN-1:0] mem_rdata,
  output logic                LS_WB_reg_valid,
  output logic [4:0]          LS_WB_reg_rd,
  output logic [DATA_LEN-1:0] LS_WB_reg_dest_data,
  output logic                LS_WB_reg_dest_wen,
  output logic                LS_WB_reg_unusual_flag,
  output logic [DATA_LEN-1:0] LS_WB_reg_cause
);

  lsu_state_e state_r, state_n;

  // Holding registers for the in-flight memory instruction
  logic [DATA_LEN-1:0] hold_addr_r;
  logic [DATA_LEN-1:0] hold_wdata_r;
  logic [3:0]          hold_wstrb_r;
  logic                hold_is_store_r;
  logic [4:0]          hold_load_sign_r;
  logic [4:0]          hold_rd_r;
  logic                hold_wen_r;
  logic [DATA_LEN-1:0] hold_dest_data_r;
  logic [DATA_LEN-1:0] hold_cause_r;

  // Writeback bundle registers and their next values
  logic                wb_valid_r, wb_valid_n;
  logic [4:0]          wb_rd_r, wb_rd_n;
  logic [DATA_LEN-1:0] wb_data_r, wb_data_n;
  logic                wb_wen_r, wb_wen_n;
  logic                wb_flag_r, wb_flag_n;
  logic [DATA_LEN-1:0] wb_cause_r, wb_cause_n;

  logic                is_store_s;
  logic                is_load_s;
  logic                is_mem_s;
  logic                misalign_s;
  logic                capture_s;
  logic [DATA_LEN-1:0] fmt_wdata_s;
  logic [3:0]          fmt_wstrb_s;
  logic [DATA_LEN-1:0] load_data_s;

  // store_sign[3] is reserved and intentionally has no effect
  logic unused_store_sign_s;
  assign unused_store_sign_s = EX_LS_reg_store_sign[3];

  // A store takes priority when both load and store types are flagged
  assign is_store_s = |EX_LS_reg_store_sign[2:0];
  assign is_load_s  = (|EX_LS_reg_load_sign) & ~is_store_s;
  assign is_mem_s   = is_store_s | is_load_s;

  // Format store data and byte strobes from the low address bits
  always_comb begin
    fmt_wdata_s = EX_LS_reg_store_data;
    fmt_wstrb_s = 4'b1111;
    if (EX_LS_reg_store_sign[SD_SB]) begin
      fmt_wdata_s = {4{EX_LS_reg_store_data[7:0]}};
      fmt_wstrb_s = 4'b0001 << EX_LS_reg_addr_load[1:0];
    end else if (EX_LS_reg_store_sign[SD_SH]) begin
      fmt_wdata_s = {2{EX_LS_reg_store_data[15:0]}};
      fmt_wstrb_s = 4'b0011 << {EX_LS_reg_addr_load[1], 1'b0};
    end else begin
      fmt_wdata_s = EX_LS_reg_store_data;
      fmt_wstrb_s = 4'b1111;
    end
  end

  // Detect misaligned half/word accesses when the exception option is built in
  always_comb begin
    misalign_s = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
    if (is_store_s) begin
      if (EX_LS_reg_store_sign[SD_SB]) begin
        misalign_s = 1'b0;
      end else if (EX_LS_reg_store_sign[SD_SH]) begin
        misalign_s = EX_LS_reg_addr_load[0];
      end else begin
        misalign_s = |EX_LS_reg_addr_load[1:0];
      end
    end else if (is_load_s) begin
      if (EX_LS_reg_load_sign[LD_LH] | EX_LS_reg_load_sign[LD_LHU]) begin
        misalign_s = EX_LS_reg_addr_load[0];
      end else if (EX_LS_reg_load_sign[LD_LW]) begin
        misalign_s = |EX_LS_reg_addr_load[1:0];
      end else begin
        misalign_s = 1'b0;
      end
    end else begin
      misalign_s = 1'b0;
    end
`else
    misalign_s = 1'b0;
`endif
  end

  lsu_load_align #(
    .DATA_LEN (DATA_LEN)
  ) u_load_align (
    .rdata     (mem_rdata),
    .addr_lo   (hold_addr_r[1:0]),
    .load_sign (hold_load_sign_r),
    .load_data (load_data_s)
  );

  // Next-state and writeback-bundle selection
  always_comb begin
    state_n    = state_r;
    capture_s  = 1'b0;
    wb_valid_n = 1'b0;
    wb_rd_n    = wb_rd_r;
    wb_data_n  = wb_data_r;
    wb_wen_n   = wb_wen_r;
    wb_flag_n  = wb_flag_r;
    wb_cause_n = wb_cause_r;
    case (state_r)
      ST_IDLE: begin
        if (EX_LS_reg_execute_valid) begin
          if (EX_LS_reg_unusual_flag || !is_mem_s) begin
            // Already-excepted or non-memory instruction: pass straight through
            wb_valid_n = 1'b1;
            wb_rd_n    = EX_LS_reg_rd;
            wb_data_n  = EX_LS_reg_dest_data;
            wb_wen_n   = EX_LS_reg_dest_wen;
            wb_flag_n  = EX_LS_reg_unusual_flag;
            wb_cause_n = EX_LS_reg_cause;
          end else if (misalign_s) begin
            wb_valid_n = 1'b1;
            wb_rd_n    = EX_LS_reg_rd;
            wb_data_n  = EX_LS_reg_dest_data;
            wb_wen_n   = 1'b0;
            wb_flag_n  = 1'b1;
            wb_cause_n = is_store_s ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
          end else begin
            capture_s = 1'b1;
            state_n   = ST_REQ;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A same-cycle rvalid here is deliberately ignored
        if (mem_gnt) begin
          if (hold_is_store_r) begin
            wb_valid_n = 1'b1;
            wb_rd_n    = hold_rd_r;
            wb_data_n  = hold_dest_data_r;
            wb_wen_n   = 1'b0;
            wb_flag_n  = 1'b0;
            wb_cause_n = hold_cause_r;
            state_n    = ST_IDLE;
          end else begin
            state_n = ST_RESP;
          end
        end else begin
          state_n = ST_REQ;
        end
      end
      ST_RESP: begin
        if (mem_rvalid) begin
          wb_valid_n = 1'b1;
          wb_rd_n    = hold_rd_r;
          wb_data_n  = load_data_s;
          wb_wen_n   = hold_wen_r;
          wb_flag_n  = 1'b0;
          wb_cause_n = hold_cause_r;
          state_n    = ST_IDLE;
        end else begin
          state_n = ST_RESP;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // State, writeback bundle and holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      wb_valid_r       <= 1'b0;
      wb_rd_r          <= 5'd0;
      wb_data_r        <= '0;
      wb_wen_r         <= 1'b0;
      wb_flag_r        <= 1'b0;
      wb_cause_r       <= '0;
      hold_addr_r      <= '0;
      hold_wdata_r     <= '0;
      hold_wstrb_r     <= 4'b0000;
      hold_is_store_r  <= 1'b0;
      hold_load_sign_r <= 5'd0;
      hold_rd_r        <= 5'd0;
      hold_wen_r       <= 1'b0;
      hold_dest_data_r <= '0;
      hold_cause_r     <= '0;
    end else begin
      state_r    <= state_n;
      wb_valid_r <= wb_valid_n;
      wb_rd_r    <= wb_rd_n;
      wb_data_r  <= wb_data_n;
      wb_wen_r   <= wb_wen_n;
      wb_flag_r  <= wb_flag_n;
      wb_cause_r <= wb_cause_n;
      if (capture_s) begin
        hold_addr_r      <= EX_LS_reg_addr_load;
        hold_wdata_r     <= fmt_wdata_s;
        hold_wstrb_r     <= is_store_s ? fmt_wstrb_s : 4'b0000;
        hold_is_store_r  <= is_store_s;
        hold_load_sign_r <= EX_LS_reg_load_sign;
        hold_rd_r        <= EX_LS_reg_rd;
        hold_wen_r       <= EX_LS_reg_dest_wen;
        hold_dest_data_r <= EX_LS_reg_dest_data;
        hold_cause_r     <= EX_LS_reg_cause;
      end
    end
  end

  // Memory port is driven only from holding registers, so it stays stable until grant
  assign mem_req   = (state_r == ST_REQ);
  assign mem_we    = mem_req & hold_is_store_r;
  assign mem_addr  = {hold_addr_r[DATA_LEN-1:2], 2'b00};
  assign mem_wdata = hold_wdata_r;
  assign mem_wstrb = hold_wstrb_r;

  assign LS_reg_ready           = (state_r == ST_IDLE);
  assign LS_WB_reg_valid        = wb_valid_r;
  assign LS_WB_reg_rd           = wb_rd_r;
  assign LS_WB_reg_dest_data    = wb_data_r;
  assign LS_WB_reg_dest_wen     = wb_wen_r;
  assign LS_WB_reg_unusual_flag = wb_flag_r;
  assign LS_WB_reg_cause        = wb_cause_r;

endmodule

// File: tb/tb_lsu_stage.sv
// ----------------------------------------------------------------------------
// tb_lsu_stage
// Directed, self-checking bench for lsu_stage. Inputs change on the falling
// edge; outputs are sampled on the falling edge, half a cycle after the
// active rising edge.
// ----------------------------------------------------------------------------
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_dest_data, ex_addr, ex_store_data, ex_cause;
  logic [4:0]  ex_load_sign, ex_rd;
  logic [3:0]  ex_store_sign;
  logic        ex_wen, ex_flag;
  logic        ready, mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, wb_wen, wb_flag;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, wb_cause;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_stage #(.DATA_LEN(32)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .EX_LS_reg_execute_valid (ex_valid),
    .EX_LS_reg_dest_data     (ex_dest_data),
    .EX_LS_reg_addr_load     (ex_addr),
    .EX_LS_reg_store_data    (ex_store_data),
    .EX_LS_reg_load_sign     (ex_load_sign),
    .EX_LS_reg_store_sign    (ex_store_sign),
    .EX_LS_reg_rd            (ex_rd),
    .EX_LS_reg_dest_wen      (ex_wen),
    .EX_LS_reg_unusual_flag  (ex_flag),
    .EX_LS_reg_cause         (ex_cause),
    .LS_reg_ready            (ready),
    .mem_req                 (mem_req),
    .mem_gnt                 (mem_gnt),
    .mem_we                  (mem_we),
    .mem_addr                (mem_addr),
    .mem_wdata               (mem_wdata),
    .mem_wstrb               (mem_wstrb),
    .mem_rvalid              (mem_rvalid),
    .mem_rdata               (mem_rdata),
    .LS_WB_reg_valid         (wb_valid),
    .LS_WB_reg_rd            (wb_rd),
    .LS_WB_reg_dest_data     (wb_data),
    .LS_WB_reg_dest_wen      (wb_wen),
    .LS_WB_reg_unusual_flag  (wb_flag),
    .LS_WB_reg_cause         (wb_cause)
  );

  task automatic ex_clear();
    ex_valid      = 1'b0;
    ex_dest_data  = 32'd0;
    ex_addr       = 32'd0;
    ex_store_data = 32'd0;
    ex_load_sign  = 5'd0;
    ex_store_sign = 4'd0;
    ex_rd         = 5'd0;
    ex_wen        = 1'b0;
    ex_flag       = 1'b0;
    ex_cause      = 32'd0;
  endtask

  task automatic ex_drive(input logic [31:0] addr, input logic [31:0] dd,
                          input logic [31:0] sd, input logic [4:0] ls,
                          input logic [3:0] ss, input logic [4:0] rd,
                          input logic wen, input logic flag,
                          input logic [31:0] cause);
    ex_valid      = 1'b1;
    ex_addr       = addr;
    ex_dest_data  = dd;
    ex_store_data = sd;
    ex_load_sign  = ls;
    ex_store_sign = ss;
    ex_rd         = rd;
    ex_wen        = wen;
    ex_flag       = flag;
    ex_cause      = cause;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_clear();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nonmem();
    ex_drive(32'd0, 32'h0000_1234, 32'd0, 5'd0, 4'd0, 5'd5, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL nonmem_valid1 got=%b exp=1", wb_valid); end
    total++; if (wb_data !== 32'h0000_1234) begin bad++; $display("FAIL nonmem_data1 got=%h exp=00001234", wb_data); end
    total++; if (wb_rd !== 5'd5 || wb_wen !== 1'b1) begin bad++; $display("FAIL nonmem_rd_wen got=%0d/%b exp=5/1", wb_rd, wb_wen); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL nonmem_ready got=%b exp=1", ready); end
    @(negedge clk);
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'h0000_1234) begin bad++; $display("FAIL nonmem_valid2 got=%b/%h exp=1/00001234", wb_valid, wb_data); end
    ex_clear();
    @(negedge clk);
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL nonmem_pulse_end got=%b exp=0", wb_valid); end
  endtask

  // Load with immediate grant; a same-cycle rvalid during REQ carries junk data
  task automatic test_load(input string name, input logic [31:0] addr,
                           input logic [4:0] ls, input logic [31:0] rdata,
                           input logic [31:0] expd);
    ex_drive(addr, 32'd0, 32'd0, ls, 4'd0, 5'd7, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    total++; if (mem_req !== 1'b1 || ready !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL %s_req req/ready/we got=%b%b%b exp=101", name, mem_req, ready, mem_we); end
    total++; if (mem_addr !== {addr[31:2], 2'b00}) begin bad++; $display("FAIL %s_addr got=%h exp=%h", name, mem_addr, {addr[31:2], 2'b00}); end
    ex_clear();
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
    total++; if (mem_req !== 1'b0 || wb_valid !== 1'b0 || ready !== 1'b0) begin bad++; $display("FAIL %s_resp req/valid/ready got=%b%b%b exp=000", name, mem_req, wb_valid, ready); end
    @(negedge clk);
    mem_rvalid = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_data !== expd) begin bad++; $display("FAIL %s_data got=%b/%h exp=1/%h", name, wb_valid, wb_data, expd); end
    total++; if (wb_rd !== 5'd7 || wb_wen !== 1'b1 || ready !== 1'b1) begin bad++; $display("FAIL %s_rd_wen_ready got=%0d/%b/%b exp=7/1/1", name, wb_rd, wb_wen, ready); end
    @(negedge clk);
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL %s_pulse_end got=%b exp=0", name, wb_valid); end
  endtask

  task automatic test_store_half();
    int req_cycles;
    req_cycles = 0;
    ex_drive(32'h0000_2002, 32'h0000_2002, 32'h0000_ABCD, 5'd0, 4'b0010, 5'd3, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    ex_clear();
    for (int i = 0; i < 4; i++) begin
      if (mem_req === 1'b1) req_cycles++;
      total++; if (mem_wstrb !== 4'b1100 || mem_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_payload%0d got=%b/%h exp=1100/abcdabcd", i, mem_wstrb, mem_wdata); end
      total++; if (ready !== 1'b0 || wb_valid !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 32'h0000_2000) begin bad++; $display("FAIL sh_hold%0d ready/valid/we/addr got=%b%b%b/%h exp=001/00002000", i, ready, wb_valid, mem_we, mem_addr); end
      mem_gnt = (i == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    total++; if (req_cycles != 4) begin bad++; $display("FAIL sh_req_cycles got=%0d exp=4", req_cycles); end
    total++; if (wb_valid !== 1'b1 || wb_wen !== 1'b0 || wb_flag !== 1'b0 || wb_rd !== 5'd3) begin bad++; $display("FAIL sh_done valid/wen/flag/rd got=%b%b%b/%0d exp=100/3", wb_valid, wb_wen, wb_flag, wb_rd); end
    total++; if (mem_req !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL sh_idle req/ready got=%b%b exp=01", mem_req, ready); end
    @(negedge clk);
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL sh_pulse_end got=%b exp=0", wb_valid); end
  endtask

  // sb with a load type also flagged: must be treated as a store
  task automatic test_store_byte_conflict();
    ex_drive(32'h0000_5001, 32'd0, 32'h1234_5677, 5'b00100, 4'b0001, 5'd9, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    total++; if (mem_we !== 1'b1 || mem_wstrb !== 4'b0010) begin bad++; $display("FAIL sb_we_strb got=%b/%b exp=1/0010", mem_we, mem_wstrb); end
    total++; if (mem_wdata !== 32'h7777_7777 || mem_addr !== 32'h0000_5000) begin bad++; $display("FAIL sb_data_addr got=%h/%h exp=77777777/00005000", mem_wdata, mem_addr); end
    ex_clear();
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_wen !== 1'b0) begin bad++; $display("FAIL sb_done got=%b/%b exp=1/0", wb_valid, wb_wen); end
    @(negedge clk);
  endtask

  task automatic test_lw_latency();
    int low, pulses;
    logic [31:0] seen;
    low = 0; pulses = 0; seen = 32'd0;
    ex_drive(32'h0000_3000, 32'd0, 32'd0, 5'b00100, 4'd0, 5'd11, 1'b1, 1'b0, 32'd0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (ready === 1'b0) low++;
      if (wb_valid === 1'b1) begin pulses++; seen = wb_data; end
      if (c == 1) ex_clear();
      mem_gnt    = (c == 1) ? 1'b1 : 1'b0;
      mem_rvalid = (c == 3) ? 1'b1 : 1'b0;
      mem_rdata  = (c == 3) ? 32'hDEAD_BEEF : 32'd0;
    end
    total++; if (low != 3) begin bad++; $display("FAIL lw_ready_low got=%0d exp=3", low); end
    total++; if (pulses != 1) begin bad++; $display("FAIL lw_pulses got=%0d exp=1", pulses); end
    total++; if (seen !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", seen); end
  endtask

  task automatic test_flag_passthrough();
    ex_drive(32'h0000_6002, 32'hAAAA_5555, 32'd0, 5'b00100, 4'd0, 5'd4, 1'b1, 1'b1, 32'd2);
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL flag_no_req req/ready got=%b%b exp=01", mem_req, ready); end
    total++; if (wb_valid !== 1'b1 || wb_flag !== 1'b1 || wb_cause !== 32'd2 || wb_data !== 32'hAAAA_5555) begin bad++; $display("FAIL flag_pass got=%b%b/%h/%h exp=11/2/aaaa5555", wb_valid, wb_flag, wb_cause, wb_data); end
    ex_clear();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    ex_drive(32'h0000_7000, 32'd0, 32'd0, 5'b00100, 4'd0, 5'd12, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    ex_clear();
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (wb_valid === 1'b1) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL rstmid_no_wb got=%0d exp=0", pulses); end
    total++; if (ready !== 1'b1 || mem_req !== 1'b0 || wb_data !== 32'd0) begin bad++; $display("FAIL rstmid_idle ready/req/data got=%b%b/%h exp=10/0", ready, mem_req, wb_data); end
  endtask

  task automatic test_misalign();
    ex_drive(32'h0000_8001, 32'd0, 32'd0, 5'b00100, 4'd0, 5'd13, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
`ifdef LSU_MISALIGN_EXC_EN
    total++; if (mem_req !== 1'b0 || ready !== 1'b1) begin bad++; $display("FAIL mis_lw_no_req req/ready got=%b%b exp=01", mem_req, ready); end
    total++; if (wb_valid !== 1'b1 || wb_flag !== 1'b1 || wb_cause !== 32'd4 || wb_wen !== 1'b0) begin bad++; $display("FAIL mis_lw_exc got=%b%b/%h/%b exp=11/4/0", wb_valid, wb_flag, wb_cause, wb_wen); end
    ex_drive(32'h0000_8003, 32'd0, 32'h0000_1111, 5'd0, 4'b0010, 5'd13, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || wb_flag !== 1'b1 || wb_cause !== 32'd6) begin bad++; $display("FAIL mis_sh_exc got=%b%b/%h exp=01/6", mem_req, wb_flag, wb_cause); end
    ex_clear();
    @(negedge clk);
`else
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_8000) begin bad++; $display("FAIL mis_off_req got=%b/%h exp=1/00008000", mem_req, mem_addr); end
    ex_clear();
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_data !== 32'hCAFE_F00D || wb_flag !== 1'b0 || wb_wen !== 1'b1) begin bad++; $display("FAIL mis_off_done got=%b/%h/%b%b exp=1/cafef00d/01", wb_valid, wb_data, wb_flag, wb_wen); end
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_load("lb",  32'h0000_1003, 5'b00001, 32'h80FF_FF00, 32'hFFFF_FF80);
    test_load("lbu", 32'h0000_1003, 5'b01000, 32'h80FF_FF00, 32'h0000_0080);
    test_load("lh",  32'h0000_1002, 5'b00010, 32'h8001_0000, 32'hFFFF_8001);
    test_load("lhu", 32'h0000_1002, 5'b10000, 32'h8001_0000, 32'h0000_8001);
    test_store_half();
    test_store_byte_conflict();
    test_lw_latency();
    test_flag_passthrough();
    test_reset_mid();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
